// File: rtl/cordic_arb_pkg.sv
// Shared definitions for the CORDIC rotation-port arbiter: default sizes,
// requester IDs and width helpers used by the arbiter and its tag FIFO.
package cordic_arb_pkg;

    localparam int DATA_W_DEF       = 16;
    localparam int ANGLE_W_DEF      = 16;
    localparam int N_REQ_DEF        = 3;
    localparam int MAX_INFLIGHT_DEF = 20;

    localparam int REQ_ID_W   = $clog2(N_REQ_DEF);
    localparam int FIFO_CNT_W = $clog2(MAX_INFLIGHT_DEF + 1);

    localparam int REQ_GSO  = 0;
    localparam int REQ_DEFL = 1;
    localparam int REQ_NORM = 2;

    function automatic int idWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cntWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cordic_tag_fifo.sv
// In-order requester-ID FIFO for CORDIC ops in flight. A pop frees the slot a
// simultaneous push needs, so push+pop at full keeps the count unchanged.
module cordic_tag_fifo
    import cordic_arb_pkg::*;
#(
    parameter int WIDTH = REQ_ID_W,
    parameter int DEPTH = MAX_INFLIGHT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = cntWidth(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/cordic_rot_arbiter.sv
// Round-robin sharing of the CORDIC rotation port with in-order result return.
// Define CORDIC_ARB_LOCK_EN to let a requester hold the grant with req_lock.
module cordic_rot_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_W_DEF,
    parameter int ANGLE_WIDTH  = ANGLE_W_DEF,
    parameter int N_REQ        = N_REQ_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_vld,
    output logic [N_REQ-1:0]             req_rdy,
    input  logic [N_REQ*DATA_WIDTH-1:0]  req_xin_flat,
    input  logic [N_REQ*DATA_WIDTH-1:0]  req_yin_flat,
    input  logic [N_REQ*ANGLE_WIDTH-1:0] req_angle_flat,
    input  logic [N_REQ*2-1:0]           req_quad_flat,
    input  logic [N_REQ-1:0]             req_angle_microRot_n_flat,
    input  logic [N_REQ-1:0]             req_lock,
    output logic [N_REQ-1:0]             rsp_vld,
    output logic [DATA_WIDTH-1:0]        rsp_xout,
    output logic [DATA_WIDTH-1:0]        rsp_yout,
    output logic                         cordic_rot_en,
    output logic [DATA_WIDTH-1:0]        cordic_rot_xin,
    output logic [DATA_WIDTH-1:0]        cordic_rot_yin,
    output logic [ANGLE_WIDTH-1:0]       cordic_rot_angle_in,
    output logic [1:0]                   cordic_rot_quad_in,
    output logic                         cordic_rot_angle_microRot_n,
    input  logic                         cordic_rot_opvld,
    input  logic [DATA_WIDTH-1:0]        cordic_rot_xout,
    input  logic [DATA_WIDTH-1:0]        cordic_rot_yout,
    output logic                         err_orphan
);

    localparam int ID_W = idWidth(N_REQ);

    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [ID_W-1:0]        grant_idx;
    logic [ID_W:0]          cand;
    logic                   grant_any, hs;
    logic                   fifo_full, fifo_empty, fifo_pop;
    logic [ID_W-1:0]        tag_dout;
    logic                   en_q, en_d;
    logic [DATA_WIDTH-1:0]  xin_q, xin_d, yin_q, yin_d;
    logic [ANGLE_WIDTH-1:0] ang_q, ang_d;
    logic [1:0]             quad_q, quad_d;
    logic                   mode_q, mode_d;
    logic [N_REQ-1:0]       rsp_vld_q, rsp_vld_d;
    logic [DATA_WIDTH-1:0]  rsp_x_q, rsp_x_d, rsp_y_q, rsp_y_d;
    logic                   err_q, err_d;

`ifdef CORDIC_ARB_LOCK_EN
    logic            lock_q, lock_d;
    logic [ID_W-1:0] lock_owner_q, lock_owner_d;
`else
    logic            lock_unused;
    assign lock_unused = ^req_lock;
`endif

    // Rotating priority search from ptr; an active lock overrides it.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!grant_any && req_vld[cand[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
`ifdef CORDIC_ARB_LOCK_EN
        if (lock_q && req_vld[lock_owner_q]) begin
            grant_any = 1'b1;
            grant_idx = lock_owner_q;
        end
`endif
    end

    assign hs      = grant_any & ~fifo_full;
    assign req_rdy = hs ? (N_REQ'(1) << grant_idx) : '0;
    assign fifo_pop = cordic_rot_opvld & ~fifo_empty;

    always_comb begin
        ptr_d  = ptr_q;
        en_d   = hs;
        xin_d  = xin_q;
        yin_d  = yin_q;
        ang_d  = ang_q;
        quad_d = quad_q;
        mode_d = mode_q;
`ifdef CORDIC_ARB_LOCK_EN
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        if (hs) begin
            lock_d       = req_lock[grant_idx];
            lock_owner_d = grant_idx;
        end else if (lock_q && !req_vld[lock_owner_q]) begin
            lock_d = 1'b0;
        end
        if (hs && !req_lock[grant_idx]) begin
            ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
`else
        if (hs) begin
            ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
`endif
        if (hs) begin
            xin_d  = req_xin_flat[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            yin_d  = req_yin_flat[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            ang_d  = req_angle_flat[grant_idx*ANGLE_WIDTH +: ANGLE_WIDTH];
            quad_d = req_quad_flat[grant_idx*2 +: 2];
            mode_d = req_angle_microRot_n_flat[grant_idx];
        end
        rsp_vld_d = fifo_pop ? (N_REQ'(1) << tag_dout) : '0;
        rsp_x_d   = fifo_pop ? cordic_rot_xout : rsp_x_q;
        rsp_y_d   = fifo_pop ? cordic_rot_yout : rsp_y_q;
        err_d     = err_q | (cordic_rot_opvld & fifo_empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            en_q      <= 1'b0;
            xin_q     <= '0;
            yin_q     <= '0;
            ang_q     <= '0;
            quad_q    <= '0;
            mode_q    <= 1'b0;
            rsp_vld_q <= '0;
            rsp_x_q   <= '0;
            rsp_y_q   <= '0;
            err_q     <= 1'b0;
`ifdef CORDIC_ARB_LOCK_EN
            lock_q       <= 1'b0;
            lock_owner_q <= '0;
`endif
        end else begin
            ptr_q     <= ptr_d;
            en_q      <= en_d;
            xin_q     <= xin_d;
            yin_q     <= yin_d;
            ang_q     <= ang_d;
            quad_q    <= quad_d;
            mode_q    <= mode_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_x_q   <= rsp_x_d;
            rsp_y_q   <= rsp_y_d;
            err_q     <= err_d;
`ifdef CORDIC_ARB_LOCK_EN
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
`endif
        end
    end

    cordic_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (hs),
        .pop   (fifo_pop),
        .din   (grant_idx),
        .dout  (tag_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cordic_rot_en               = en_q;
    assign cordic_rot_xin              = xin_q;
    assign cordic_rot_yin              = yin_q;
    assign cordic_rot_angle_in         = ang_q;
    assign cordic_rot_quad_in          = quad_q;
    assign cordic_rot_angle_microRot_n = mode_q;
    assign rsp_vld                     = rsp_vld_q;
    assign rsp_xout                    = rsp_x_q;
    assign rsp_yout                    = rsp_y_q;
    assign err_orphan                  = err_q;

endmodule

// File: tb/tb_cordic_rot_arbiter.sv
// Bench for cordic_rot_arbiter: requester drivers, a stallable fake CORDIC
// pipeline, and a queue-based model of grants and in-order result ownership.
module tb_cordic_rot_arbiter;

    localparam int N    = 3;
    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int MAXF = 20;
    localparam int LAT  = 4;

    typedef struct {
        int          owner;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] a;
        logic [1:0]  q;
        logic        m;
        int          t;
    } op_t;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_vld;
    logic [N-1:0]      req_rdy;
    logic [N*DW-1:0]   req_xin_flat;
    logic [N*DW-1:0]   req_yin_flat;
    logic [N*AW-1:0]   req_angle_flat;
    logic [N*2-1:0]    req_quad_flat;
    logic [N-1:0]      req_angle_microRot_n_flat;
    logic [N-1:0]      req_lock;
    logic [N-1:0]      rsp_vld;
    logic [DW-1:0]     rsp_xout, rsp_yout;
    logic              cordic_rot_en;
    logic [DW-1:0]     cordic_rot_xin, cordic_rot_yin;
    logic [AW-1:0]     cordic_rot_angle_in;
    logic [1:0]        cordic_rot_quad_in;
    logic              cordic_rot_angle_microRot_n;
    logic              cordic_rot_opvld;
    logic [DW-1:0]     cordic_rot_xout, cordic_rot_yout;
    logic              err_orphan;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          remaining [N];
    int          opsDone   [N];
    logic [N-1:0] lockEn   = '0;
    logic [N-1:0] hsSeen   = '0;
    logic        stall     = 1'b0;
    logic        oneShot   = 1'b0;
    int          grantLog [$];
    logic [N-1:0] rspOwnerLog [$];
    logic [15:0] rspXLog [$];
    logic [15:0] rspYLog [$];
    int          rspCount    = 0;
    int          lastHsCycle = 0;
    int          lastEnCycle = 0;

    op_t  cq [$];
    op_t  mq [$];
    op_t  mPop, mNew;
    int   mPtr    = 0;
    int   expG    = 0;
    logic mLocked = 1'b0;
    int   mOwner  = 0;
    logic mWasEmpty;
    logic [N-1:0] expRdy = '0;
    logic         expEn  = 1'b0;
    op_t          expIss;
    logic [N-1:0] expRsp = '0;
    logic [15:0]  expRx  = '0;
    logic [15:0]  expRy  = '0;
    logic         expErr = 1'b0;

    cordic_rot_arbiter #(
        .DATA_WIDTH   (DW),
        .ANGLE_WIDTH  (AW),
        .N_REQ        (N),
        .MAX_INFLIGHT (MAXF)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .req_vld                     (req_vld),
        .req_rdy                     (req_rdy),
        .req_xin_flat                (req_xin_flat),
        .req_yin_flat                (req_yin_flat),
        .req_angle_flat              (req_angle_flat),
        .req_quad_flat               (req_quad_flat),
        .req_angle_microRot_n_flat   (req_angle_microRot_n_flat),
        .req_lock                    (req_lock),
        .rsp_vld                     (rsp_vld),
        .rsp_xout                    (rsp_xout),
        .rsp_yout                    (rsp_yout),
        .cordic_rot_en               (cordic_rot_en),
        .cordic_rot_xin              (cordic_rot_xin),
        .cordic_rot_yin              (cordic_rot_yin),
        .cordic_rot_angle_in         (cordic_rot_angle_in),
        .cordic_rot_quad_in          (cordic_rot_quad_in),
        .cordic_rot_angle_microRot_n (cordic_rot_angle_microRot_n),
        .cordic_rot_opvld            (cordic_rot_opvld),
        .cordic_rot_xout             (cordic_rot_xout),
        .cordic_rot_yout             (cordic_rot_yout),
        .err_orphan                  (err_orphan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] opX(input int i, input int n);
        return 16'(100 + 37 * i + 5 * n);
    endfunction
    function automatic logic [15:0] opY(input int i, input int n);
        return 16'(11 * i + 3 * n);
    endfunction
    function automatic logic [15:0] opA(input int i, input int n);
        return 16'(7 * i + n);
    endfunction

    // Fake CORDIC transfer: gain K ~ 0.6073 (39797/65536) plus visible operand tags.
    function automatic logic [15:0] fx(input op_t e);
        int t;
        t = (int'(e.x) * 39797) >>> 16;
        return 16'(t + int'(e.a));
    endfunction
    function automatic logic [15:0] fy(input op_t e);
        int t;
        t = (int'(e.y) * 39797) >>> 16;
        return 16'(t + int'(e.q) + int'(e.m));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Requesters: hold operands until their handshake, then advance to the next op.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (hsSeen[i]) begin
                if (remaining[i] > 0) remaining[i]--;
                opsDone[i]++;
            end
            req_vld[i]                   = (remaining[i] > 0);
            req_lock[i]                  = lockEn[i];
            req_xin_flat[i*DW +: DW]     = opX(i, opsDone[i]);
            req_yin_flat[i*DW +: DW]     = opY(i, opsDone[i]);
            req_angle_flat[i*AW +: AW]   = opA(i, opsDone[i]);
            req_quad_flat[i*2 +: 2]      = 2'((i + opsDone[i]) % 4);
            req_angle_microRot_n_flat[i] = 1'((i + opsDone[i]) % 2);
        end
        hsSeen = '0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (req_vld[i] && req_rdy[i]) begin
                    hsSeen[i]   = 1'b1;
                    grantLog.push_back(i);
                    lastHsCycle = cyc;
                end
            end
        end
        if (cordic_rot_en) begin
            lastEnCycle = cyc;
            cq.push_back('{owner: -1, x: cordic_rot_xin, y: cordic_rot_yin, a: cordic_rot_angle_in,
                           q: cordic_rot_quad_in, m: cordic_rot_angle_microRot_n, t: cyc});
        end
        if (rsp_vld != '0) begin
            rspCount++;
            rspOwnerLog.push_back(rsp_vld);
            rspXLog.push_back(rsp_xout);
            rspYLog.push_back(rsp_yout);
        end
    end

    // In-order CORDIC stand-in; keeps its contents across the arbiter's reset.
    always @(posedge clk) begin
        cyc++;
        #1;
        cordic_rot_opvld = 1'b0;
        if (cq.size() > 0 && (!stall || oneShot) && (cyc - cq[0].t >= LAT)) begin
            cordic_rot_opvld = 1'b1;
            cordic_rot_xout  = fx(cq[0]);
            cordic_rot_yout  = fy(cq[0]);
            void'(cq.pop_front());
            oneShot = 1'b0;
        end
    end

    // Model: ownership queue, rotating pointer, full/empty rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mPtr    = 0;
            mLocked = 1'b0;
            expEn   = 1'b0;
            expRsp  = '0;
            expRx   = '0;
            expRy   = '0;
            expErr  = 1'b0;
        end else begin
            mWasEmpty = (mq.size() == 0);
            expEn     = 1'b0;
            expRsp    = '0;
            if (cordic_rot_opvld) begin
                if (mWasEmpty) begin
                    expErr = 1'b1;
                end else begin
                    mPop   = mq.pop_front();
                    expRsp = N'(1) << mPop.owner;
                    expRx  = fx(mPop);
                    expRy  = fy(mPop);
                end
            end
            if (expRdy != '0) begin
                mNew = '{owner: expG, x: req_xin_flat[expG*DW +: DW], y: req_yin_flat[expG*DW +: DW],
                         a: req_angle_flat[expG*AW +: AW], q: req_quad_flat[expG*2 +: 2],
                         m: req_angle_microRot_n_flat[expG], t: 0};
                mq.push_back(mNew);
                expEn  = 1'b1;
                expIss = mNew;
`ifdef CORDIC_ARB_LOCK_EN
                if (req_lock[expG]) begin
                    mLocked = 1'b1;
                    mOwner  = expG;
                end else begin
                    mLocked = 1'b0;
                    mPtr    = (expG + 1) % N;
                end
`else
                mPtr = (expG + 1) % N;
`endif
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        expG   = -1;
        expRdy = '0;
        if (mLocked && !req_vld[mOwner]) mLocked = 1'b0;
        if (mLocked) begin
            expG = mOwner;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (expG < 0 && req_vld[(mPtr + k) % N]) expG = (mPtr + k) % N;
            end
        end
        if (expG >= 0 && mq.size() < MAXF) expRdy = N'(1) << expG;
        checkOutput("req_rdy", 32'(req_rdy), 32'(expRdy));
        checkOutput("issue_en", 32'(cordic_rot_en), 32'(expEn));
        if (expEn) begin
            checkOutput("issue_x", 32'(cordic_rot_xin), 32'(expIss.x));
            checkOutput("issue_y", 32'(cordic_rot_yin), 32'(expIss.y));
            checkOutput("issue_angle", 32'(cordic_rot_angle_in), 32'(expIss.a));
            checkOutput("issue_quad", 32'(cordic_rot_quad_in), 32'(expIss.q));
            checkOutput("issue_mode", 32'(cordic_rot_angle_microRot_n), 32'(expIss.m));
        end
        checkOutput("rsp_vld", 32'(rsp_vld), 32'(expRsp));
        if (expRsp != '0) begin
            checkOutput("rsp_x", 32'(rsp_xout), 32'(expRx));
            checkOutput("rsp_y", 32'(rsp_yout), 32'(expRy));
        end
        checkOutput("err_orphan", 32'(err_orphan), 32'(expErr));
    end

    task automatic applyStimulus(input int r0, input int r1, input int r2);
        @(negedge clk);
        #2;
        remaining[0] = r0;
        remaining[1] = r1;
        remaining[2] = r2;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < N; i++) remaining[i] = 0;
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int bound);
        bit done;
        done = 0;
        for (int k = 0; k < bound && !done; k++) begin
            @(negedge clk);
            if (remaining[0] == 0 && remaining[1] == 0 && remaining[2] == 0 && req_vld == '0 &&
                mq.size() == 0 && cq.size() == 0 && !cordic_rot_en && !cordic_rot_opvld && rsp_vld == '0)
                done = 1;
        end
        if (!done) checkOutput(name, 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic waitCq(input string name, input int target, input int bound);
        bit done;
        done = 0;
        for (int k = 0; k < bound && !done; k++) begin
            @(negedge clk);
            if (cq.size() == target) done = 1;
        end
        if (!done) checkOutput(name, 0, 1);
    endtask

    initial begin
        int expOrder [8];
        int g0, r0;
        for (int i = 0; i < N; i++) begin
            remaining[i] = 0;
            opsDone[i]   = 0;
        end
        req_vld = '0; req_lock = '0;
        req_xin_flat = '0; req_yin_flat = '0; req_angle_flat = '0;
        req_quad_flat = '0; req_angle_microRot_n_flat = '0;
        cordic_rot_opvld = 1'b0; cordic_rot_xout = '0; cordic_rot_yout = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_en", 32'(cordic_rot_en), 0);
        checkOutput("reset_rsp_vld", 32'(rsp_vld), 0);
        checkOutput("reset_err", 32'(err_orphan), 0);
        checkOutput("reset_rdy", 32'(req_rdy), 0);
        #2 rst = 1'b0;

        // Single op from requester 0: x=100, y=0, angle=0.
        applyStimulus(1, 0, 0);
        waitIdle("timeout_single", 100);
        checkOutput("single_latency", 32'(lastEnCycle - lastHsCycle), 1);
        checkOutput("single_rsp_count", 32'(rspOwnerLog.size()), 1);
        if (rspOwnerLog.size() > 0) begin
            checkOutput("single_rsp_owner", 32'(rspOwnerLog[0]), 32'b001);
            checkOutput("single_rsp_x", 32'(rspXLog[0]), 60);
            checkOutput("single_rsp_y", 32'(rspYLog[0]), 0);
        end

        // All three requesting from a fresh pointer: 0,1,2,0,1,2.
        pulseReset();
        grantLog.delete();
        rspOwnerLog.delete();
        applyStimulus(2, 2, 2);
        waitIdle("timeout_rr", 200);
        expOrder = '{0, 1, 2, 0, 1, 2, 0, 0};
        checkOutput("rr_grant_count", 32'(grantLog.size()), 6);
        checkOutput("rr_rsp_count", 32'(rspOwnerLog.size()), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < grantLog.size()) checkOutput($sformatf("rr_grant%0d", k), 32'(grantLog[k]), 32'(expOrder[k]));
            if (k < rspOwnerLog.size())
                checkOutput($sformatf("rr_rsp_owner%0d", k), 32'(rspOwnerLog[k]), 32'(1) << expOrder[k]);
        end

        // Move the pointer to 1, then requester 1 bursts with req_lock set.
        applyStimulus(1, 0, 0);
        waitIdle("timeout_prep", 100);
        grantLog.delete();
        lockEn = 3'b010;
        applyStimulus(2, 4, 2);
        waitIdle("timeout_lock", 300);
        lockEn = '0;
        checkOutput("lock_grant_count", 32'(grantLog.size()), 8);
`ifdef CORDIC_ARB_LOCK_EN
        expOrder = '{1, 1, 1, 1, 2, 0, 2, 0};
`else
        expOrder = '{1, 2, 0, 1, 2, 0, 1, 1};
`endif
        for (int k = 0; k < 5; k++) begin
            if (k < grantLog.size()) checkOutput($sformatf("lock_grant%0d", k), 32'(grantLog[k]), 32'(expOrder[k]));
        end

        // Fill the tag FIFO with the CORDIC stalled, then release one result.
        stall = 1'b1;
        applyStimulus(0, 0, MAXF + 3);
        waitCq("timeout_fill", MAXF, 200);
        repeat (3) @(negedge clk);
        checkOutput("full_rdy", 32'(req_rdy), 0);
        checkOutput("full_inflight", 32'(cq.size()), MAXF);
        g0 = grantLog.size();
        #2 oneShot = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("full_one_more", 32'(grantLog.size() - g0), 1);
        checkOutput("full_rdy_again", 32'(req_rdy), 0);
        #2 stall = 1'b0;
        waitIdle("timeout_drain", 400);

        // Reset with 5 ops in flight; the stale results must be dropped.
        stall = 1'b1;
        applyStimulus(5, 0, 0);
        waitCq("timeout_orphan_fill", 5, 200);
        pulseReset();
        r0 = rspCount;
        #2 stall = 1'b0;
        waitCq("timeout_orphan_drain", 0, 100);
        repeat (3) @(negedge clk);
        checkOutput("orphan_no_rsp", 32'(rspCount - r0), 0);
        checkOutput("orphan_err", 32'(err_orphan), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
